mux8_rr_scheduler: RTL and testbench
====================================

# mux8_rr_scheduler

Round-robin scheduler that shares one 8-to-1, 1-bit multiplexer (`mux8x1`) between eight requesters. Each requester raises a request; the scheduler grants one at a time, drives the mux select lines, and forwards the granted requester's data bit to a single output. The block sits in front of the lab's `mux8x1` datapath and replaces hand-driven select stimulus with a clocked controller.

## Interface
- `HOLD_MAX`, 4: maximum consecutive cycles one requester may hold the grant; legal range 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  8  request per requester; bit i belongs to requester i.
- `din`  in  8  data bit per requester; bit i feeds mux input Ii.
- `sel`  out  3  registered mux select, {s2,s1,s0} = granted index.
- `gnt`  out  8  registered one-hot grant; all zero when idle.
- `valid`  out  1  registered; high while any grant is active.
- `dout`  out  1  mux output F = `din[sel]` when `valid`, else 0.

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: one requester owns the mux.
- Round-robin pointer `last` (3 bits) holds the most recently granted index. The search order is `last+1, last+2, … last` modulo 8, so the current owner has lowest priority and is still eligible.
- Transitions:
  - IDLE → GRANT when `req != 0`. The winner is the first set bit in search order. `hold_cnt` ← 1.
  - GRANT stays on the same owner when `req[sel]` = 1 and `hold_cnt < HOLD_MAX`. `hold_cnt` increments.
  - GRANT re-arbitrates when `req[sel]` = 0 or `hold_cnt == HOLD_MAX`:
    - A new winner is picked in the same edge, with no idle bubble, and `hold_cnt` ← 1.
    - If only the current owner still requests, it is re-granted.
    - If `req == 0`, the state goes to IDLE.
- On every new grant: `last` ← winner, `sel` ← winner, `gnt` ← one-hot(winner), `valid` ← 1.
- On IDLE entry: `gnt` ← 0, `valid` ← 0. `sel` keeps its last value and `dout` is forced to 0.
- `hold_cnt` width is 4 bits. It never exceeds `HOLD_MAX` and does not wrap.
- Requests are level-sensitive. A requester may drop `req` at any time; the grant is withdrawn at the next edge.
- `din` has no handshake. The owner must hold its data valid while `gnt[i]` is high.

## Timing
- Reset values: `sel`=3'b000, `gnt`=8'h00, `valid`=0, `dout`=0, `last`=3'd7 (so the first search starts at index 0), `hold_cnt`=0, state IDLE.
- Reset asserted mid-grant clears all state immediately, without waiting for the clock.
- Latency:
  - `req[i]` sampled high at edge k in IDLE gives `gnt[i]`, `sel`, `valid` high after edge k.
  - `dout` follows `din[sel]` combinationally in the same cycle.
- Release latency: `req[i]` low at edge k gives `gnt[i]` low after edge k.
- With all 8 requesting continuously, each owner holds for exactly `HOLD_MAX` cycles. The order is 0,1,…,7,0.
- If a release and a new request land on the same edge, the new request competes in that same edge's arbitration.

## Structure
- Shared package `mux8_pkg` holds:
  - state enum {IDLE, GRANT};
  - constants `N_REQ`=8 and `SEL_W`=3;
  - a pure function `rr_pick(req, last)` returning {found, index}.
- One sub-module: an instance of the existing `mux8x1`, connected as `din[0..7]`, `sel[0]`/`sel[1]`/`sel[2]` → s0/s1/s2, output ANDed with `valid` to form `dout`.
- Keep the arbitration logic (state, pointer, counter) in the top module.

## Test plan
- Reset: hold `rst`=1 with `req`=8'hFF → `gnt`=0, `sel`=0, `valid`=0, `dout`=0. Release `rst` → after the first edge `gnt`=8'h01, `sel`=0.
- Single requester: `req`=8'h20, `din`=8'h20 → `gnt`=8'h20, `sel`=5, `dout`=1. With `HOLD_MAX`=4, after 4 cycles the same requester is re-granted with no gap. Dropping `req` → IDLE next edge, `dout`=0.
- Fairness: `req`=8'hFF held for 32 cycles with `HOLD_MAX`=4 → grant sequence 0..7, each for exactly 4 cycles.
- Early release: `req`=8'h81 with owner 0. Drop `req[0]` → the next edge grants index 7 with no idle cycle. Then `req`=8'h00 → `valid`=0.
- Wrap-around: `last`=6 with `req`=8'h41 → the next grant goes to 0, not 6.
- Async reset mid-grant: assert `rst` between edges while `gnt`=8'h08 → `gnt`, `valid`, `dout` clear immediately, and after release the search restarts at index 0.

Source files
------------

// File: rtl/mux8_pkg.sv
// Shared types, constants and the round-robin search helper for the 8-way mux scheduler.
package mux8_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] index;
   } pick_t;

   // Search starts just after last and ends on last itself, so the previous owner ranks lowest.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] last);
      pick_t            r;
      logic [SEL_W-1:0] idx;
      r = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = last + SEL_W'(k);
         if (!r.found && req[idx]) begin
            r.found = 1'b1;
            r.index = idx;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux8x1.sv
// Lab 8-to-1, 1-bit multiplexer: F = I[{s2,s1,s0}].
module mux8x1 (
   input  logic i0,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   input  logic i4,
   input  logic i5,
   input  logic i6,
   input  logic i7,
   input  logic s0,
   input  logic s1,
   input  logic s2,
   output logic f
);

   always_comb begin
      f = i0;
      case ({s2, s1, s0})
         3'd0: f = i0;
         3'd1: f = i1;
         3'd2: f = i2;
         3'd3: f = i3;
         3'd4: f = i4;
         3'd5: f = i5;
         3'd6: f = i6;
         3'd7: f = i7;
         default: f = i0;
      endcase
   end

endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one mux8x1 between eight requesters, with a per-owner hold limit.
module mux8_rr_scheduler
   import mux8_pkg::*;
#(
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] din,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             valid,
   output logic             dout
);

   state_t           state_reg, state_next;
   logic [SEL_W-1:0] last_reg, last_next;
   logic [SEL_W-1:0] sel_reg, sel_next;
   logic [N_REQ-1:0] gnt_reg, gnt_next;
   logic             valid_reg, valid_next;
   logic [3:0]       hold_cnt_reg, hold_cnt_next;

   pick_t            pick;
   logic [N_REQ-1:0] pick_onehot;
   logic             rearb;
   logic             mux_f;

   assign pick = rr_pick(req, last_reg);

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign pick_onehot[gi] = (pick.index == SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         last_reg     <= 3'd7;
         sel_reg      <= '0;
         gnt_reg      <= '0;
         valid_reg    <= 1'b0;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         last_reg     <= last_next;
         sel_reg      <= sel_next;
         gnt_reg      <= gnt_next;
         valid_reg    <= valid_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      last_next     = last_reg;
      sel_next      = sel_reg;
      gnt_next      = gnt_reg;
      valid_next    = valid_reg;
      hold_cnt_next = hold_cnt_reg;
      rearb         = 1'b0;

      case (state_reg)
         IDLE: rearb = 1'b1;
         GRANT: begin
            if (req[sel_reg] && (hold_cnt_reg < 4'(HOLD_MAX)))
               hold_cnt_next = hold_cnt_reg + 4'd1;
            else
               rearb = 1'b1;
         end
         default: rearb = 1'b1;
      endcase

      // Re-arbitration hands over in the same edge; only an empty req falls back to IDLE.
      if (rearb) begin
         if (pick.found) begin
            state_next    = GRANT;
            last_next     = pick.index;
            sel_next      = pick.index;
            gnt_next      = pick_onehot;
            valid_next    = 1'b1;
            hold_cnt_next = 4'd1;
         end else begin
            state_next    = IDLE;
            gnt_next      = '0;
            valid_next    = 1'b0;
            hold_cnt_next = '0;
         end
      end
   end

   mux8x1 u_mux (
      .i0 (din[0]),
      .i1 (din[1]),
      .i2 (din[2]),
      .i3 (din[3]),
      .i4 (din[4]),
      .i5 (din[5]),
      .i6 (din[6]),
      .i7 (din[7]),
      .s0 (sel_reg[0]),
      .s1 (sel_reg[1]),
      .s2 (sel_reg[2]),
      .f  (mux_f)
   );

   assign sel   = sel_reg;
   assign gnt   = gnt_reg;
   assign valid = valid_reg;
   assign dout  = mux_f & valid_reg;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed self-checking bench for mux8_rr_scheduler with HOLD_MAX = 4.
module tb_mux8_rr_scheduler;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] din;
   logic [2:0] sel;
   logic [7:0] gnt;
   logic       valid;
   logic       dout;

   int n_checks;
   int n_errors;

   mux8_rr_scheduler #(.HOLD_MAX(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .din   (din),
      .sel   (sel),
      .gnt   (gnt),
      .valid (valid),
      .dout  (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int own;
      n_checks = 0;
      n_errors = 0;

      // Reset held with all requesting
      rst = 1'b1;
      req = 8'hFF;
      din = 8'hFF;
      repeat (3) step();
      check_value("rst_gnt", 32'(gnt), 32'h00);
      check_value("rst_sel", 32'(sel), 32'h0);
      check_value("rst_valid", 32'(valid), 32'h0);
      check_value("rst_dout", 32'(dout), 32'h0);

      // Release reset; first edge grants index 0
      din = 8'hAA;
      rst = 1'b0;
      step();
      check_value("first_gnt", 32'(gnt), 32'h01);
      check_value("first_sel", 32'(sel), 32'h0);
      check_value("first_valid", 32'(valid), 32'h1);
      check_value("first_dout", 32'(dout), 32'h0);

      // Fairness: each owner holds exactly 4 cycles in order 0..7, then back to 0
      for (int c = 1; c <= 32; c++) begin
         step();
         own = (c / 4) % 8;
         check_value($sformatf("fair_gnt_c%0d", c), 32'(gnt), 32'(8'h01 << own));
         check_value($sformatf("fair_sel_c%0d", c), 32'(sel), 32'(own));
         check_value($sformatf("fair_dout_c%0d", c), 32'(dout), 32'((8'hAA >> own) & 8'h01));
      end

      req = 8'h00;
      step();
      check_value("fair_idle_valid", 32'(valid), 32'h0);
      check_value("fair_idle_gnt", 32'(gnt), 32'h00);

      // Single requester 5: re-granted after the hold limit with no gap
      req = 8'h20;
      din = 8'h20;
      for (int c = 0; c < 8; c++) begin
         step();
         check_value($sformatf("single_gnt_c%0d", c), 32'(gnt), 32'h20);
         check_value($sformatf("single_valid_c%0d", c), 32'(valid), 32'h1);
      end
      check_value("single_sel", 32'(sel), 32'h5);
      check_value("single_dout1", 32'(dout), 32'h1);
      din = 8'hDF;
      #1;
      check_value("single_dout0", 32'(dout), 32'h0);
      din = 8'hFF;
      req = 8'h00;
      step();
      check_value("single_idle_gnt", 32'(gnt), 32'h00);
      check_value("single_idle_valid", 32'(valid), 32'h0);
      check_value("single_idle_sel", 32'(sel), 32'h5);
      check_value("single_idle_dout", 32'(dout), 32'h0);

      // Early release: owner 0 drops, 7 takes over on the same edge
      req = 8'h01;
      step();
      check_value("early_own0", 32'(gnt), 32'h01);
      req = 8'h81;
      step();
      check_value("early_hold0", 32'(gnt), 32'h01);
      req = 8'h80;
      step();
      check_value("early_gnt7", 32'(gnt), 32'h80);
      check_value("early_sel7", 32'(sel), 32'h7);
      check_value("early_valid7", 32'(valid), 32'h1);
      req = 8'h00;
      step();
      check_value("early_idle_valid", 32'(valid), 32'h0);

      // Wrap-around: last = 6, req = 41 picks 0 first
      req = 8'h40;
      step();
      check_value("wrap_gnt6", 32'(gnt), 32'h40);
      req = 8'h00;
      step();
      check_value("wrap_idle", 32'(valid), 32'h0);
      req = 8'h41;
      step();
      check_value("wrap_gnt0", 32'(gnt), 32'h01);
      for (int c = 0; c < 3; c++) begin
         step();
         check_value($sformatf("wrap_hold0_c%0d", c), 32'(gnt), 32'h01);
      end
      step();
      check_value("wrap_handoff6", 32'(gnt), 32'h40);
      check_value("wrap_handoff_sel", 32'(sel), 32'h6);

      // Async reset mid-grant while owner is 3
      req = 8'h00;
      step();
      req = 8'h08;
      din = 8'h08;
      step();
      check_value("arst_pre_gnt", 32'(gnt), 32'h08);
      check_value("arst_pre_dout", 32'(dout), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check_value("arst_gnt", 32'(gnt), 32'h00);
      check_value("arst_valid", 32'(valid), 32'h0);
      check_value("arst_dout", 32'(dout), 32'h0);
      check_value("arst_sel", 32'(sel), 32'h0);
      req = 8'hFF;
      step();
      rst = 1'b0;
      step();
      check_value("arst_restart_gnt", 32'(gnt), 32'h01);
      check_value("arst_restart_sel", 32'(sel), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
